// File: rtl/fifo_pkg.sv
// Shared widths, buffer depth and byte type for the syn_fifo read-side logic.
package fifo_pkg;
    localparam int DW_DEFAULT    = 8;
    localparam int CNT_W_DEFAULT = 16;
    localparam int RDBUF_DEPTH   = 2;

    typedef logic [DW_DEFAULT-1:0] byte_t;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry ring buffer absorbing FIFO read latency; head is registered storage.
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic [DW-1:0] head
);
    logic [DW-1:0] mem [RDBUF_DEPTH];
    logic          hd;
    logic          tl;

    // Tail sits one past head only when exactly one entry is held; at occ=2
    // the tail aliases the head slot, which is only written while it is popped.
    assign tl   = hd ^ occ[0];
    assign head = mem[hd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            hd     <= 1'b0;
            occ    <= 2'd0;
        end else if (flush) begin
            hd  <= 1'b0;
            occ <= 2'd0;
        end else begin
            if (push) mem[tl] <= din;
            if (pop)  hd <= ~hd;
            if (push && !pop)      occ <= occ + 2'd1;
            else if (!push && pop) occ <= occ - 2'd1;
        end
    end
endmodule

// File: rtl/fifo_rd_stream.sv
// Read engine for syn_fifo: issues re against the empty flag and streams bytes out
// through a 2-entry buffer on a valid/ready interface.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             fifo_e,
    output logic             fifo_re,
    input  logic [DW-1:0]    fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             busy
);
    logic [1:0]       occ;
    logic             inflight;
    logic             pop;
    logic             pop_eff;
    logic             push;
    logic [2:0]       level;
    logic [CNT_W-1:0] cnt_q;

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;
    assign pop_eff = pop && !flush;
    assign push    = inflight && !flush;

    // Bytes that will occupy the buffer after this cycle if no new read is issued.
    assign level   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_re = !rst && en && !flush && !fifo_e && (level < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            cnt_q    <= '0;
        end else begin
            inflight <= fifo_re;
            if (pop_eff) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    skid_buf2 #(.DW(DW)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   (fifo_dout),
        .pop   (pop_eff),
        .occ   (occ),
        .head  (m_data)
    );

    assign rd_cnt = cnt_q;
    assign busy   = (occ != 2'd0) || inflight;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a behavioural syn_fifo model.
module tb_fifo_rd_stream;
    logic        clk;
    logic        rst;
    logic        en;
    logic        flush;
    logic        fifo_e;
    logic        fifo_re;
    logic [7:0]  fifo_dout;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [15:0] rd_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int re_cnt = 0;

    logic [7:0] fifo_q [$];
    logic [7:0] wr_q   [$];
    logic [7:0] exp_q  [$];
    int         pop_cyc [$];

    logic       re_s = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    fifo_rd_stream #(.DW(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .fifo_e    (fifo_e),
        .fifo_re   (fifo_re),
        .fifo_dout (fifo_dout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .rd_cnt    (rd_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // syn_fifo model: registered read data, empty flag updated on the edge
    initial begin
        fifo_e    = 1'b1;
        fifo_dout = 8'h00;
    end
    always @(posedge clk) begin
        if (re_s) begin
            if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
            else begin
                bad++;
                $display("FAIL fifo_underflow: read of empty fifo at cycle %0d", cyc);
            end
        end
        while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
        fifo_e <= (fifo_q.size() == 0);
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        re_s = fifo_re;
        if (!rst) begin
            if (fifo_re) re_cnt++;
            if (fifo_re && fifo_e) begin
                bad++;
                $display("FAIL re_while_empty: fifo_re=1 with fifo_e=1 at cycle %0d", cyc);
            end
            if (dut.occ > 2'd2 || (dut.occ == 2'd2 && dut.inflight && !(m_valid && m_ready) && !flush)) begin
                bad++;
                $display("FAIL overflow_guard: occ=%0d inflight=%0d at cycle %0d", dut.occ, dut.inflight, cyc);
            end
            if (stall_prev && m_valid && m_data !== data_prev) begin
                bad++;
                $display("FAIL stall_stable: m_data=%0h want %0h at cycle %0d", m_data, data_prev, cyc);
            end
            if (m_valid && m_ready && !flush) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got byte %0h, none expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        bad++;
                        $display("FAIL sb_data: got %0h want %0h at cycle %0d", m_data, e, cyc);
                    end
                end
                pop_cyc.push_back(cyc);
            end
            stall_prev = m_valid && !m_ready;
            data_prev  = m_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        wr_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit toggle, input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || busy || fifo_q.size() != 0 || wr_q.size() != 0) && n < maxc) begin
            step();
            if (toggle) m_ready = ~m_ready;
            n++;
        end
        total++;
        if (n >= maxc) begin
            bad++;
            $display("FAIL drain_timeout: %0d bytes still expected after %0d cycles", exp_q.size(), n);
        end
        m_ready = 1'b1;
    endtask

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fifo_re", {31'd0, fifo_re}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_rd_cnt", {16'd0, rd_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // streaming at full rate
        en = 1'b1; m_ready = 1'b1;
        pop_cyc.delete();
        wr(8'h11); wr(8'h22); wr(8'h33);
        drain(1'b0, 30);
        chk("t1_rd_cnt", {16'd0, rd_cnt}, 32'd3);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_pops", pop_cyc.size(), 32'd3);
        if (pop_cyc.size() == 3) chk("t1_consecutive", pop_cyc[2] - pop_cyc[0], 32'd2);

        // back-pressure with a full FIFO
        m_ready = 1'b0;
        step();
        re_cnt = 0;
        for (int i = 0; i < 8; i++) wr(8'(i));
        repeat (10) step();
        chk("t2_stall_re", re_cnt, 32'd2);
        chk("t2_stall_valid", {31'd0, m_valid}, 32'd1);
        chk("t2_stall_data", {24'd0, m_data}, 32'd0);
        m_ready = 1'b1;
        drain(1'b0, 40);
        chk("t2_rd_cnt", {16'd0, rd_cnt}, 32'd11);

        // alternating ready
        for (int i = 0; i < 8; i++) wr(8'(i));
        drain(1'b1, 80);
        chk("t3_rd_cnt", {16'd0, rd_cnt}, 32'd19);

        // flush with two bytes pending and a capture due
        m_ready = 1'b0;
        step();
        for (int i = 0; i < 8; i++) wr(8'h40 + 8'(i));
        n = 0;
        do begin
            step();
            n++;
        end while (!(dut.occ == 2'd1 && dut.inflight) && n < 20);
        chk("t4_reach_state", {31'd0, (n < 20)}, 32'd1);
        flush = 1'b1;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        @(negedge clk);
        chk("t4_no_re_in_flush", {31'd0, fifo_re}, 32'd0);
        step();
        flush = 1'b0;
        chk("t4_valid_after", {31'd0, m_valid}, 32'd0);
        chk("t4_busy_after", {31'd0, busy}, 32'd0);
        chk("t4_rd_cnt_held", {16'd0, rd_cnt}, 32'd19);
        m_ready = 1'b1;
        drain(1'b0, 40);
        chk("t4_rd_cnt", {16'd0, rd_cnt}, 32'd25);

        // en low with one read in flight and four bytes left in the FIFO
        en = 1'b0;
        for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i));
        step();
        en = 1'b1;
        step();
        en = 1'b0;
        re_cnt = 0;
        repeat (10) step();
        chk("t5_no_re", re_cnt, 32'd0);
        chk("t5_left", exp_q.size(), 32'd4);
        chk("t5_rd_cnt", {16'd0, rd_cnt}, 32'd26);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        en = 1'b1;
        drain(1'b0, 30);
        chk("t5_rd_cnt_end", {16'd0, rd_cnt}, 32'd30);

        // counter wrap
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        step();
        release dut.cnt_q;
        wr(8'h60); wr(8'h61); wr(8'h62);
        drain(1'b0, 30);
        chk("t6_wrap", {16'd0, rd_cnt}, 32'h0001);

        // asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) wr(8'h70 + 8'(i));
        repeat (3) @(posedge clk);
        #2;
        chk("t6_pre_rst", {30'd0, m_valid, fifo_re}, 32'd3);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("t6_rst_re", {31'd0, fifo_re}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_cnt", {16'd0, rd_cnt}, 32'd0);
        exp_q.delete();
        fifo_q.delete();
        wr_q.delete();
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
